// File: rtl/msg_encrypt6.sv
// msg_encrypt6: builds a 64-character LFSR-encrypted frame (preamble + plaintext)
// in data memory at FRAME_LEN..FRAME_LEN+63, one character per cycle.
`default_nettype none

module msg_encrypt6 #(
  parameter int FRAME_LEN = 64,
  parameter int PRE_MIN   = 7
) (
  input  logic       clk,
  input  logic       init,
  input  logic       start,
  input  logic [2:0] tap_sel,
  input  logic [5:0] seed,
  input  logic [5:0] pre_len,
  input  logic [7:0] data_out,
  output logic [7:0] raddr,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] PRE_MIN_W   = 6'(PRE_MIN);
  localparam logic [7:0] FRAME_BASE  = 8'(FRAME_LEN);
  localparam logic [7:0] PREAMBLE_CH = 8'h5F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] k_q, k_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [5:0] taps_q, taps_d;
  logic [5:0] pre_q, pre_d;

  logic [5:0] taps_sel;
  logic       in_preamble;
  logic [7:0] plain;

  always_comb begin
    case (tap_sel)
      3'd1:    taps_sel = 6'h2D;
      3'd2:    taps_sel = 6'h30;
      3'd3:    taps_sel = 6'h33;
      3'd4:    taps_sel = 6'h36;
      3'd5:    taps_sel = 6'h39;
      default: taps_sel = 6'h21;
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lfsr_d  = lfsr_q;
    taps_d  = taps_q;
    pre_d   = pre_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        taps_d  = taps_sel;
        lfsr_d  = (seed == 6'd0) ? 6'h01 : seed;
        pre_d   = (pre_len < PRE_MIN_W) ? PRE_MIN_W : pre_len;
        k_d     = 6'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        lfsr_d = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
        if (k_q == 6'd63) state_d = S_DONE;
        else              k_d     = k_q + 6'd1;
      end
      S_DONE: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= S_IDLE;
      k_q     <= 6'd0;
      lfsr_q  <= 6'd0;
      taps_q  <= 6'd0;
      pre_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      taps_q  <= taps_d;
      pre_q   <= pre_d;
    end
  end

  // Outputs decode straight from the registers so reset kills wr_en immediately.
  assign in_preamble = (k_q < pre_q);
  assign plain       = in_preamble ? PREAMBLE_CH : data_out;

  always_comb begin
    wr_en   = 1'b0;
    waddr   = 8'd0;
    raddr   = 8'd0;
    data_in = 8'd0;
    if (state_q == S_RUN) begin
      wr_en   = 1'b1;
      waddr   = FRAME_BASE + {2'b00, k_q};
      raddr   = in_preamble ? 8'd0 : {2'b00, k_q - pre_q};
      data_in = plain ^ {2'b00, lfsr_q};
    end
  end

  assign busy = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: doc/msg_encrypt6.md
# msg_encrypt6

Encryption-side counterpart of the lab 5 LFSR decrypt DUT. On a `start` pulse the block builds a 64-character ciphertext frame in data memory at addresses 64..127. Each frame is a run of preamble characters `0x5F` followed by plaintext read from addresses 0..63. Every character is XORed on its low 6 bits with successive states of a 6-bit LFSR, using one of six fixed tap patterns. The block drives the same combinational-read `dat_mem` port set as the decrypt DUT, so the decrypt DUT can consume its output frame directly.

## Interface
- `FRAME_LEN`, 64: ciphertext characters per frame; also the ciphertext base address.
- `PRE_MIN`, 7: minimum preamble length. Lower requests clamp up to this value.
- `clk` in 1: single clock; all state updates on its rising edge.
- `init` in 1: asynchronous, active-high reset.
- `start` in 1: begin a frame. Sampled only in IDLE and DONE.
- `tap_sel` in 3: tap index 0..5 selecting 0x21, 0x2D, 0x30, 0x33, 0x36, 0x39. Values 6 and 7 select index 0.
- `seed` in 6: LFSR starting state. A value of 0 is replaced by 6'h01.
- `pre_len` in 6: preamble length, clamped to the range PRE_MIN..63.
- `data_out` in 8: memory read data. Combinational from `raddr`.
- `raddr` out 8: memory read address.
- `waddr` out 8: memory write address.
- `data_in` out 8: memory write data.
- `wr_en` out 1: memory write strobe.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: high in DONE.

## Operation
States and transitions:
- **IDLE**: if `start`, go to LOAD.
- **LOAD**: latch the clamped `tap_sel`, `seed` and `pre_len` into registers. Set LFSR state to seed and k to 0. Go to RUN.
- **RUN**: one character per cycle. When k==63, go to DONE; otherwise k increments.
- **DONE**: `done` held high. If `start`, go to LOAD; otherwise stay.

LFSR rule:
- next state = {s[4:0], ^(s & taps)}.
- s(0) = seed; advances once per RUN cycle.

Plaintext selection at frame index k:
- k < pre_len: P = 8'h5F, and `raddr` = 0.
- k >= pre_len: `raddr` = k − pre_len, and P = `data_out`.

Outputs in RUN:
- `wr_en` = 1.
- `waddr` = FRAME_LEN + k.
- `data_in` = P ^ {2'b00, s(k)}. Bits [7:6] pass through unchanged.

Outputs outside RUN: `wr_en`, `waddr`, `raddr` and `data_in` are all 0.

Other rules:
- Configuration inputs are ignored outside LOAD. Changing them mid-frame has no effect.
- `start` in LOAD or RUN is ignored.
- k is 6 bits. 63 wraps to 0 only via LOAD, never mid-frame.
- Plaintext addresses used run from 0 to 63 − pre_len. Memory above that is never read.

## Timing
- Reset values: state IDLE; k, LFSR and config registers 0; all outputs 0.
- Reset mid-frame: `wr_en` drops asynchronously with `init`, with no further writes. Memory keeps the partial frame.
- Outputs are combinational from state, k and the LFSR register. They carry no registered lag.
- Edge numbering, with the edge that samples `start` counted as edge 0:
  - edge 0: enter LOAD.
  - edge 1: enter RUN with k=0.
  - RUN spans 64 cycles; the write of k lands at edge k+2.
  - edge 65: enter DONE; `done` is high after edge 65.
- Latency from `start` to `done` is 65 cycles. Throughput is one character per cycle.
- `done` deasserts on the edge that samples `start` in DONE.

## Test plan
- **Base frame**: tap_sel=0, seed=6'h01, pre_len=7, mem[0..56]=8'h41.
  - Expect mem[64]=8'h5E, mem[65]=8'h5C, mem[66]=8'h58.
  - Expect mem[71]=8'h41 ^ {2'b00, s(7)}.
  - Expect `done` high after edge 65 and exactly 64 `wr_en` cycles.
- **Each tap pattern**: run tap_sel 0..5 with random seeds and pre_len=10.
  - Ciphertext matches a reference model.
  - Feeding the memory to the decrypt DUT restores mem[0..53] and strips the preamble.
- **Clamping**:
  - pre_len=3 gives a frame identical to pre_len=7.
  - tap_sel=7 gives a frame identical to tap_sel=0.
  - seed=0 gives a frame identical to seed=1.
- **Reset mid-frame**: assert `init` at k=20.
  - `wr_en` is 0 in the same cycle; `busy` and `done` are 0; mem[85..127] is untouched.
  - A new `start` then writes the full frame.
- **Start handling**:
  - `start` held high for the whole frame produces exactly one frame.
  - A `start` pulse in DONE restarts: `done` falls on the next edge, and a frame with new config is written.
  - Config changes during RUN do not alter the ciphertext.
